// File: rtl/ara_vprof_ctrl.sv
// Profiling window controller: saturating runtime/event counters, idle-gated snapshots, 1-deep read port.
// Optional live-counter read window enabled by defining ARA_VPROF_LIVE_READ_EN.

module ara_vprof_cnt #(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                    cnt_o <= '0;
        else if (clr_i)                 cnt_o <= '0;
        else if (inc_i && cnt_o != '1)  cnt_o <= cnt_o + W'(1);
    end
endmodule

module ara_vprof_ctrl #(
    parameter int unsigned NrEvents = 3,
    parameter int unsigned CntWidth = 64,
    parameter int unsigned IdleHold = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sw_en_i,
    input  logic                sw_clr_i,
    input  logic                vinsn_valid_i,
    input  logic                ara_idle_i,
    input  logic [NrEvents-1:0] event_i,
    input  logic                rd_valid_i,
    input  logic [3:0]          rd_idx_i,
    output logic                rd_ready_o,
    output logic                rsp_valid_o,
    output logic [CntWidth-1:0] rsp_data_o,
    output logic                rsp_err_o,
    input  logic                rsp_ready_i,
    output logic                busy_o,
    output logic                snap_pulse_o
);
    localparam int unsigned QW = $clog2(IdleHold + 1);

    typedef enum logic {Idle, Run} state_e;
    state_e state_q, state_d;

    logic [CntWidth-1:0]               runtime_q, runtime_buf_q;
    logic [NrEvents-1:0][CntWidth-1:0] event_q, event_buf_q;
    logic [7:0]                        snap_cnt_q;
    logic                              pending_q;
    logic [QW-1:0]                     quiet_q, quiet_d;
    logic                              cnt_en, snap;
    logic [CntWidth-1:0]               rd_data;
    logic                              rd_err;

    // Counting is gated by the registered state, so it begins the cycle after entering Run.
    assign cnt_en = (state_q == Run);

    ara_vprof_cnt #(.W(CntWidth)) i_runtime_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (sw_clr_i),
        .inc_i  (cnt_en),
        .cnt_o  (runtime_q)
    );

    for (genvar i = 0; i < NrEvents; i++) begin : g_evt
        ara_vprof_cnt #(.W(CntWidth)) i_evt_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (sw_clr_i),
            .inc_i  (cnt_en & event_i[i]),
            .cnt_o  (event_q[i])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:    if (sw_en_i && vinsn_valid_i) state_d = Run;
            Run:     if (!sw_en_i && ara_idle_i)   state_d = Idle;
            default: state_d = Idle;
        endcase
        if (sw_clr_i) state_d = Idle;
    end

    // Snapshot fires in the cycle the quiet run reaches IdleHold, so a dispatch that cycle vetoes it.
    always_comb begin
        quiet_d = '0;
        if (ara_idle_i && !vinsn_valid_i)
            quiet_d = (quiet_q == QW'(IdleHold)) ? quiet_q : quiet_q + QW'(1);
    end

    assign snap = pending_q && (quiet_d == QW'(IdleHold)) && !sw_clr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            runtime_buf_q <= '0;
            event_buf_q   <= '0;
            snap_cnt_q    <= '0;
            pending_q     <= 1'b0;
            quiet_q       <= '0;
        end else if (sw_clr_i) begin
            state_q       <= Idle;
            runtime_buf_q <= '0;
            event_buf_q   <= '0;
            snap_cnt_q    <= '0;
            pending_q     <= 1'b0;
            quiet_q       <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            if (snap) begin
                runtime_buf_q <= runtime_q;
                event_buf_q   <= event_q;
                snap_cnt_q    <= snap_cnt_q + 8'd1;
            end
            if (vinsn_valid_i) pending_q <= 1'b1;
            else if (snap)     pending_q <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (rd_idx_i == 4'd0) begin
            rd_data = runtime_buf_q;
            rd_err  = 1'b0;
        end
        for (int i = 0; i < NrEvents; i++) begin
            if (rd_idx_i == 4'(i + 1)) begin
                rd_data = event_buf_q[i];
                rd_err  = 1'b0;
            end
        end
        if (rd_idx_i == 4'(NrEvents + 1)) begin
            rd_data = CntWidth'(snap_cnt_q);
            rd_err  = 1'b0;
        end
`ifdef ARA_VPROF_LIVE_READ_EN
        if (rd_idx_i == 4'(NrEvents + 2)) begin
            rd_data = runtime_q;
            rd_err  = 1'b0;
        end
        for (int i = 0; i < NrEvents; i++) begin
            if (rd_idx_i == 4'(NrEvents + 3 + i)) begin
                rd_data = event_q[i];
                rd_err  = 1'b0;
            end
        end
`endif
    end

    assign rd_ready_o = !rsp_valid_o || rsp_ready_i;

    // Response path ignores sw_clr_i so an in-flight read completes with its sampled value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else if (rd_valid_i && rd_ready_o) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rd_data;
            rsp_err_o   <= rd_err;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

    assign busy_o       = (state_q == Run);
    assign snap_pulse_o = snap;
endmodule

// File: tb/tb_ara_vprof_ctrl.sv
// Directed + randomized bench for ara_vprof_ctrl against a cycle-level behavioural model.
module tb_ara_vprof_ctrl;
    localparam int NE = 3;
    localparam int CW = 8;
    localparam int H  = 2;
    localparam longint unsigned MAX = (64'd1 << CW) - 1;

    logic          clk = 1'b0, rst_n;
    logic          sw_en, sw_clr, vin, ara_idle, rd_valid, rsp_ready;
    logic [NE-1:0] event_v;
    logic [3:0]    rd_idx;
    logic          rd_ready_o, rsp_valid_o, rsp_err_o, busy_o, snap_pulse_o;
    logic [CW-1:0] rsp_data_o;

    ara_vprof_ctrl #(.NrEvents(NE), .CntWidth(CW), .IdleHold(H)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .sw_clr_i(sw_clr),
        .vinsn_valid_i(vin), .ara_idle_i(ara_idle), .event_i(event_v),
        .rd_valid_i(rd_valid), .rd_idx_i(rd_idx), .rd_ready_o(rd_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .rsp_ready_i(rsp_ready), .busy_o(busy_o), .snap_pulse_o(snap_pulse_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    bit              m_run, m_pend, m_rv, m_re;
    int              m_quiet, m_snaps;
    longint unsigned m_rt, m_rbuf, m_rd;
    longint unsigned m_ev[NE], m_ebuf[NE];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_run = 0; m_pend = 0; m_quiet = 0; m_snaps = 0; m_rt = 0; m_rbuf = 0;
        for (int i = 0; i < NE; i++) begin m_ev[i] = 0; m_ebuf[i] = 0; end
    endfunction

    function automatic void mread(input int idx, output longint unsigned d, output bit e);
        d = 0; e = 0;
        if (idx == 0)            d = m_rbuf;
        else if (idx <= NE)      d = m_ebuf[idx-1];
        else if (idx == NE + 1)  d = longint'(m_snaps);
`ifdef ARA_VPROF_LIVE_READ_EN
        else if (idx == NE + 2)  d = m_rt;
        else if (idx <= 2*NE+2)  d = m_ev[idx-NE-3];
`endif
        else                     e = 1;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cyc(input int exp_snap = -1);
        int qn; bit snap, rdy; longint unsigned d; bit e;
        @(negedge clk);
        qn   = (ara_idle && !vin) ? ((m_quiet + 1 > H) ? H : m_quiet + 1) : 0;
        snap = !sw_clr && m_pend && (qn == H);
        rdy  = !m_rv || rsp_ready;
        check("busy", 64'(busy_o), 64'(m_run));
        check("snap", 64'(snap_pulse_o), 64'(snap));
        check("rd_ready", 64'(rd_ready_o), 64'(rdy));
        check("rsp_valid", 64'(rsp_valid_o), 64'(m_rv));
        if (m_rv) begin
            check("rsp_data", 64'(rsp_data_o), m_rd);
            check("rsp_err", 64'(rsp_err_o), 64'(m_re));
        end
        if (exp_snap >= 0) check("snap_dir", 64'(snap_pulse_o), 64'(exp_snap));
        @(posedge clk);
        if (rd_valid && rdy) begin
            mread(int'(rd_idx), d, e);
            m_rv = 1; m_rd = d; m_re = e;
        end else if (rsp_ready) m_rv = 0;
        if (sw_clr) m_clear();
        else begin
            if (snap) begin
                m_rbuf = m_rt; m_ebuf = m_ev; m_snaps = (m_snaps + 1) % 256; m_pend = 0;
            end
            if (vin) m_pend = 1;
            if (m_run) begin
                if (m_rt != MAX) m_rt++;
                for (int i = 0; i < NE; i++) if (event_v[i] && m_ev[i] != MAX) m_ev[i]++;
            end
            m_quiet = qn;
            if (!m_run && sw_en && vin)          m_run = 1;
            else if (m_run && !sw_en && ara_idle) m_run = 0;
        end
        #1;
    endtask

    task automatic rd(input int idx, output longint unsigned d, output bit e);
        rd_valid = 1; rd_idx = 4'(idx); rsp_ready = 1;
        cyc();
        rd_valid = 0;
        d = longint'(rsp_data_o); e = rsp_err_o;
    endtask

    task automatic clear();
        sw_clr = 1; cyc(); sw_clr = 0;
    endtask

    initial begin
        longint unsigned d; bit e;
        rst_n = 0; sw_en = 0; sw_clr = 0; vin = 0; ara_idle = 0; event_v = '0;
        rd_valid = 0; rd_idx = '0; rsp_ready = 0;
        m_clear(); m_rv = 0; m_rd = 0; m_re = 0;
        #1;
        check("rst_rd_ready", 64'(rd_ready_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_snap", 64'(snap_pulse_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Basic window: dispatch at cycle 10, busy until 29, sw_en drops at 25.
        rsp_ready = 1; sw_en = 1; ara_idle = 1;
        repeat (10) cyc();
        vin = 1; ara_idle = 0; cyc(); vin = 0;
        repeat (14) cyc();
        sw_en = 0; repeat (5) cyc();
        ara_idle = 1; cyc(0);
        cyc(1);
        check("t1_idle_after", 64'(busy_o), 64'd0);
        rd(0, d, e);
        check("t1_runtime", d, 64'd20);
        check("t1_err", 64'(e), 64'd0);

        // Events counted only in Run, 7 strobes.
        clear();
        sw_en = 1; vin = 1; ara_idle = 0; event_v = 3'b010; cyc(); vin = 0;
        repeat (7) cyc();
        event_v = '0; sw_en = 0; ara_idle = 1;
        repeat (3) cyc();
        rd(2, d, e);
        check("t2_evt1", d, 64'd7);

        // Saturation of runtime and event 0.
        clear();
        sw_en = 1; vin = 1; ara_idle = 0; cyc(); vin = 0;
        event_v = 3'b001;
        repeat (300) cyc();
        event_v = '0; sw_en = 0; ara_idle = 1;
        repeat (3) cyc();
        rd(0, d, e); check("t2_rt_sat", d, MAX);
        rd(1, d, e); check("t2_ev0_sat", d, MAX);
        rd(2, d, e); check("t2_ev1_zero", d, 64'd0);

        // Dispatch in would-be snapshot cycle suppresses it.
        clear();
        vin = 1; ara_idle = 1; cyc(0);
        vin = 0; cyc(0);
        vin = 1; cyc(0);
        vin = 0; cyc(0);
        cyc(1);
        cyc(0);
        rd(NE + 1, d, e);
        check("t3_snap_cnt", d, 64'd1);

        // Handshake: hold response for 3 cycles.
        rd_valid = 1; rd_idx = 4'(NE + 1); rsp_ready = 0; cyc(); rd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_rd_ready_held", 64'(rd_ready_o), 64'd0);
            check("t5_data_stable", 64'(rsp_data_o), 64'd1);
        end
        rsp_ready = 1; cyc();
        rd(9, d, e);
        check("t5_idx9_err", 64'(e), 64'd1);
        check("t5_idx9_data", d, 64'd0);
        rd(15, d, e);
        check("t5_idx15_err", 64'(e), 64'd1);
        rd_valid = 1;
        for (int i = 0; i < 4; i++) begin rd_idx = 4'(i * 3); cyc(); end
        rd_valid = 0; cyc();

        // Clear priority with a same-cycle read of the old buffer.
        clear();
        sw_en = 1; vin = 1; ara_idle = 0; cyc(); vin = 0;
        repeat (20) cyc();
        ara_idle = 1; cyc(0); cyc(1);
        ara_idle = 0; repeat (28) cyc();
        sw_clr = 1; rd_valid = 1; rd_idx = 4'd0; cyc();
        sw_clr = 0; rd_valid = 0; sw_en = 0;
        check("t4_old_buf", 64'(rsp_data_o), 64'd21);
        check("t4_busy_cleared", 64'(busy_o), 64'd0);
        cyc();
        rd(0, d, e);      check("t4_rt_buf_zero", d, 64'd0);
        rd(NE + 1, d, e); check("t4_snaps_zero", d, 64'd0);

        // Live window.
        clear();
        sw_en = 1; vin = 1; ara_idle = 0; cyc(); vin = 0;
        repeat (10) cyc();
        rd(NE + 2, d, e);
`ifdef ARA_VPROF_LIVE_READ_EN
        check("t6_live_rt", d, 64'd10);
        check("t6_live_err", 64'(e), 64'd0);
`else
        check("t6_nolive_err", 64'(e), 64'd1);
        check("t6_nolive_data", d, 64'd0);
`endif
        rd(0, d, e); check("t6_buf_unchanged", d, 64'd0);

        // Asynchronous reset mid-Run.
        repeat (3) cyc();
        @(negedge clk); #2 rst_n = 0; #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_rd_ready", 64'(rd_ready_o), 64'd1);
        check("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        m_clear(); m_rv = 0;
        @(posedge clk); #1 rst_n = 1;
        sw_en = 0; ara_idle = 1;
        rd(0, d, e); check("arst_rt_buf", d, 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 19) == 0) sw_en = ~sw_en;
            vin       = ($urandom_range(0, 9) == 0);
            ara_idle  = ($urandom_range(0, 9) < 7);
            event_v   = NE'($urandom);
            sw_clr    = ($urandom_range(0, 199) == 0);
            rd_valid  = ($urandom_range(0, 9) < 4);
            rd_idx    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
